// File: rtl/ahb_simple_master_if.sv
// rtl/ahb_simple_master_if.sv - AHB-Lite bus bundle between the simple master and a slave
interface ahb_simple_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_simple_master.sv
// rtl/ahb_simple_master.sv - single-outstanding AHB-Lite master driven by a command/response handshake
module ahb_simple_master #(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         CHECK_ALIGN = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [1:0]           cmd_size,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  ahb_simple_master_if.master  ahb
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        write_q, err_q;
  logic        accept, reject;

  // A rejected command skips the bus and goes straight to a response.
  always_comb begin
    reject = CHECK_ALIGN && ((cmd_size == 2'd3) ||
                             (cmd_size == 2'd1 && cmd_addr[0]) ||
                             (cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00));
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = reject ? RESP : ADDR;
      ADDR:    if (ahb.HREADY) state_nxt = DATA;
      DATA:    if (ahb.HREADY) state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == IDLE) && !HRESET;
    busy       = (state != IDLE) && !HRESET;
    rsp_valid  = (state == RESP);
    ahb.HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
  end

  // Address-phase fields persist past ADDR so the bus holds its last values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        size_q  <= cmd_size;
        write_q <= cmd_write;
        wdata_q <= cmd_wdata;
        if (reject) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state == DATA && ahb.HREADY) begin
        rdata_q <= write_q ? 32'h0 : ahb.HRDATA;
        err_q   <= ahb.HRESP;
      end
    end
  end

  assign ahb.HADDR     = addr_q;
  assign ahb.HWRITE    = write_q;
  assign ahb.HSIZE     = {1'b0, size_q};
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = wdata_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_ahb_simple_master.sv
// tb/tb_ahb_simple_master.sv - directed vector bench for ahb_simple_master with a small slave model
module tb_ahb_simple_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_simple_master_if bus ();

  ahb_simple_master #(.HPROT_VAL(4'b0011), .CHECK_ALIGN(1'b1)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ahb       (bus.master)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] hrdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nonseq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_size  = 2'd3;
    cmd_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat = 0, nonseq = 0, held = 0, dcnt = 0;
    bit          dphase = 0, done = 0, addr_ok = 1, idle_ok = 1;
    logic [31:0] r_rdata = 'x;
    logic        r_err = 1'bx;
    @(negedge HCLK);
    check($sformatf("v%0d cmd_ready_idle", idx), {31'b0, cmd_ready}, 32'd1);
    issue_cmd(v.write, v.addr, v.size, v.wdata);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge HCLK);
      if (bus.HTRANS == 2'b10) begin
        nonseq++;
        if (bus.HADDR !== v.addr || bus.HSIZE !== {1'b0, v.size} || bus.HWRITE !== v.write) addr_ok = 0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        dphase     = 1;
        dcnt       = 0;
      end else begin
        if (bus.HTRANS !== 2'b00) idle_ok = 0;
        if (dphase) begin
          if (v.write && bus.HWDATA === v.wdata) held++;
          bus.HRESP = v.err;
          if (dcnt < v.waits) begin
            bus.HREADY = 1'b0;
            bus.HRDATA = 32'hBAD0_BAD0;
            dcnt++;
          end else begin
            bus.HREADY = 1'b1;
            bus.HRDATA = v.hrdata;
            dphase     = 0;
          end
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = 1'b0;
        end
      end
      if (rsp_valid) begin
        lat     = c;
        r_rdata = rsp_rdata;
        r_err   = rsp_err;
        check($sformatf("v%0d cmd_ready_in_resp", idx), {31'b0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        done      = 1;
      end
    end
    if (done) begin
      @(posedge HCLK);
      #1;
      rsp_ready = 1'b0;
      bus.HRESP = 1'b0;
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d rsp_rdata", idx), r_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_err", idx), {31'b0, r_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d nonseq_count", idx), nonseq, v.exp_nonseq);
    check($sformatf("v%0d htrans_idle_outside_addr", idx), {31'b0, idle_ok}, 32'd1);
    if (v.exp_nonseq > 0)
      check($sformatf("v%0d addr_phase_fields", idx), {31'b0, addr_ok}, 32'd1);
    if (v.write && v.exp_nonseq > 0)
      check($sformatf("v%0d hwdata_held_cycles", idx), held, v.waits + 1);
  endtask

  initial begin
    logic [31:0] cap;
    bit          stable, none;
    bit          got;

    vecs[0] = '{1'b0, 32'h0000_0010, 2'd2, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1};
    vecs[1] = '{1'b1, 32'h2000_0003, 2'd0, 32'h5500_0000, 2, 1'b0, 32'h1111_1111, 32'h0,         1'b0, 5, 1};
    vecs[2] = '{1'b0, 32'h0000_0102, 2'd1, 32'h0,         1, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 4, 1};
    vecs[3] = '{1'b0, 32'h0000_0002, 2'd2, 32'h0,         0, 1'b0, 32'h2222_2222, 32'h0,         1'b1, 1, 0};
    vecs[4] = '{1'b1, 32'h0000_0000, 2'd3, 32'h1234_5678, 0, 1'b0, 32'h0,         32'h0,         1'b1, 1, 0};
    vecs[5] = '{1'b0, 32'h0000_0101, 2'd1, 32'h0,         0, 1'b0, 32'h3333_3333, 32'h0,         1'b1, 1, 0};
    vecs[6] = '{1'b1, 32'h0000_0040, 2'd2, 32'hA5A5_5A5A, 0, 1'b0, 32'h4444_4444, 32'h0,         1'b0, 3, 1};
    vecs[7] = '{1'b1, 32'h0000_0044, 2'd2, 32'hCAFE_0001, 1, 1'b1, 32'h5555_5555, 32'h0,         1'b1, 4, 1};
    vecs[8] = '{1'b0, 32'h0000_0007, 2'd0, 32'h0,         0, 1'b0, 32'h0000_00AB, 32'h0000_00AB, 1'b0, 3, 1};

    HRESET     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_size   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("reset htrans", {30'b0, bus.HTRANS}, 32'd0);
    check("reset haddr", bus.HADDR, 32'd0);
    check("reset hwdata", bus.HWDATA, 32'd0);
    check("reset hsize_hwrite", {28'b0, bus.HSIZE, bus.HWRITE}, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);
    check("reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("const hprot_hburst_lock", {24'b0, bus.HPROT, bus.HBURST, bus.HMASTLOCK}, {24'b0, 4'b0011, 3'b000, 1'b0});
    HRESET = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Response backpressure: rsp_ready low for 4 cycles.
    @(negedge HCLK);
    issue_cmd(1'b0, 32'h0000_0080, 2'd2, 32'h0);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge HCLK);
      bus.HREADY = 1'b1;
      bus.HRDATA = 32'h0BAD_F00D;
      if (rsp_valid) got = 1;
    end
    check("bp rsp_valid_seen", {31'b0, got}, 32'd1);
    cap    = rsp_rdata;
    check("bp rsp_rdata", cap, 32'h0BAD_F00D);
    stable = 1;
    for (int c = 0; c < 4; c++) begin
      bus.HRDATA = 32'h7777_0000 + c;
      @(negedge HCLK);
      if (!rsp_valid || rsp_rdata !== cap || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) stable = 0;
    end
    check("bp held_stable", {31'b0, stable}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge HCLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge HCLK);
    check("bp released", {30'b0, rsp_valid, cmd_ready}, 32'd1);

    // Reset pulsed during the data phase abandons the transfer.
    issue_cmd(1'b0, 32'h0000_00C0, 2'd2, 32'h0);
    @(negedge HCLK);
    check("rst addr_phase", {30'b0, bus.HTRANS}, 32'd2);
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    check("rst data_phase", {29'b0, bus.HTRANS, busy}, 32'd1);
    bus.HREADY = 1'b0;
    HRESET     = 1'b1;
    @(negedge HCLK);
    check("rst htrans_after", {30'b0, bus.HTRANS}, 32'd0);
    check("rst rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    check("rst busy_cmd_ready_during", {30'b0, busy, cmd_ready}, 32'd0);
    check("rst haddr_cleared", bus.HADDR, 32'd0);
    HRESET = 1'b0;
    #1;
    check("rst cmd_ready_released", {31'b0, cmd_ready}, 32'd1);
    bus.HREADY = 1'b1;
    none = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00) none = 0;
    end
    check("rst no_response", {31'b0, none}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_simple_master.md
AHB_SIMPLE_MASTER -- requirements
Module: ahb_simple_master

Interface
REQ-001 Parameter: HPROT_VAL, 4'b0011, constant value driven on HPROT for every transfer.
REQ-002 Parameter: CHECK_ALIGN, 1, when 1 misaligned or illegal-size commands are rejected without bus activity.
REQ-003 Port: HCLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: HRESET  input  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  input  1  requester presents a command.
REQ-006 Port: cmd_ready  output  1  block accepts the command this cycle.
REQ-007 Port: cmd_write  input  1  1 = write, 0 = read.
REQ-008 Port: cmd_addr  input  32  byte address.
REQ-009 Port: cmd_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-010 Port: cmd_wdata  input  32  write data, already lane-aligned by the requester.
REQ-011 Port: rsp_valid  output  1  response available.
REQ-012 Port: rsp_ready  input  1  requester consumes the response.
REQ-013 Port: rsp_rdata  output  32  read data; 0 for writes and rejected commands.
REQ-014 Port: rsp_err  output  1  1 = slave error or rejected command.
REQ-015 Port: busy  output  1  high in any state other than IDLE.
REQ-016 AHB-Lite master ports: HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HMASTLOCK out 1, HWDATA out 32, HRDATA in 32, HREADY in 1, HRESP in 1.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA and RESP, with exactly one transfer outstanding at a time.
REQ-018 cmd_ready SHALL be 1 only in IDLE with HRESET low; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-019 On acceptance, the block SHALL register addr, size, write and wdata.
- Legal command: next state ADDR.
- Rejected command (CHECK_ALIGN=1 and one of: size 3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0): next state RESP with rsp_err=1, rsp_rdata=0, and no bus transfer.
REQ-020 ADDR state outputs SHALL be: HTRANS=2'b10 (NONSEQ), HADDR=registered addr, HWRITE=registered write, HSIZE={1'b0,size}, HBURST=3'b000, HMASTLOCK=0, HPROT=HPROT_VAL.
REQ-021 ADDR SHALL hold all address-phase outputs stable until an edge with HREADY=1, then move to DATA.
REQ-022 In DATA, HTRANS SHALL be 2'b00 (IDLE). When write, HWDATA SHALL equal the registered wdata for the entire data phase.
REQ-023 DATA SHALL wait while HREADY=0 with no timeout. On the edge with HREADY=1 it SHALL:
- capture rsp_rdata = (read ? HRDATA : 0);
- set rsp_err = HRESP;
- move to RESP.
REQ-024 An error cycle (HRESP=1, HREADY=0) SHALL cause no state change and SHALL keep HTRANS at IDLE; completion is taken on the following HREADY=1 cycle.
REQ-025 RESP SHALL assert rsp_valid with rsp_rdata and rsp_err stable until an edge with rsp_ready=1, then move to IDLE; rsp_ready is ignored outside RESP.
REQ-026 Outside ADDR, HTRANS SHALL be 2'b00 and HADDR/HWRITE/HSIZE SHALL hold their last values.
REQ-027 Latency with a zero-wait slave: accept at edge N, ADDR during cycle N+1, DATA during N+2, rsp_valid from N+3. A rejected command gives rsp_valid from N+1.
REQ-028 Back-to-back: with rsp_ready held at 1, the next command can be accepted 1 cycle after the response handshake, which is the earliest point because IDLE is re-entered first.

Reset
REQ-029 While HRESET=1 at an edge, the block SHALL set:
- state=IDLE;
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 While HRESET=1, busy SHALL be 0 and cmd_ready SHALL be 0; HBURST, HMASTLOCK and HPROT are constants and unaffected by reset.
REQ-031 Reset asserted in ADDR, DATA or RESP SHALL abandon the transfer: HTRANS=00 from the edge that samples HRESET=1, and no response is produced.

Verification
REQ-032 Word read, zero-wait: cmd addr=0x00000010, size=2, HRDATA=0xDEADBEEF -> HTRANS=10 for 1 cycle, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 Byte write with 2 wait states: addr=0x20000003, size=0, wdata=0x55000000, HREADY low 2 cycles in DATA -> HSIZE=000, HWDATA=0x55000000 held 3 cycles, rsp_valid at N+5, rsp_err=0.
REQ-034 Slave error: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 in DATA -> no new NONSEQ issued, rsp_err=1.
REQ-035 Misaligned: size=2, addr=0x00000002 -> HTRANS stays 00 throughout, rsp_valid at N+1, rsp_err=1, rsp_rdata=0.
REQ-036 Backpressure and reset: rsp_ready=0 for 4 cycles -> rsp_valid and data stable, cmd_ready=0; separately, HRESET=1 pulsed during DATA -> next cycle HTRANS=00, rsp_valid=0, and cmd_ready=1 once HRESET returns to 0.
